// File: rtl/fifo_level_if.sv
// Handshake and status bundle between a FIFO client (master) and
// fifo_level_unit (slave). Widths must match the FIFO instance parameters.
interface fifo_level_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic                  rd;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, flush, clr_err, w_data,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr, rd, flush, clr_err, w_data,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_level_unit.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and an optional
// registered read port. The level register alone tells full from empty, so
// the pointers carry no extra wrap bit.
module fifo_level_unit #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1,
    parameter int OUT_REG    = 0
) (
    input  logic            clk,
    input  logic            reset,
    fifo_level_if.slave     bus
);
    localparam int DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_AF   = LW'(AF_LEVEL);
    localparam logic [LW-1:0]         LVL_AE   = LW'(AE_LEVEL);
    localparam logic [LW-1:0]         LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]         LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_s, empty_s, wr_acc_s, rd_acc_s;

    // Occupancy flags derived purely from the level register.
    always_comb begin
        full_s  = (level_q == LVL_FULL);
        empty_s = (level_q == LVL_ZERO);
    end

    // Accept decisions, pointer/level next state and sticky error flags.
    always_comb begin
        wr_acc_s    = bus.wr & ~full_s  & ~bus.flush;
        rd_acc_s    = bus.rd & ~empty_s & ~bus.flush;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            w_ptr_d = PTR_ZERO;
            r_ptr_d = PTR_ZERO;
            level_d = LVL_ZERO;
        end else begin
            if (wr_acc_s) begin
                w_ptr_d = w_ptr_q + PTR_ONE;
            end else begin
                w_ptr_d = w_ptr_q;
            end
            if (rd_acc_s) begin
                r_ptr_d = r_ptr_q + PTR_ONE;
            end else begin
                r_ptr_d = r_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        // A new error event outranks a simultaneous clear.
        if (bus.wr & full_s & ~bus.flush) begin
            overflow_d = 1'b1;
        end else if (bus.clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.rd & empty_s & ~bus.flush) begin
            underflow_d = 1'b1;
        end else if (bus.clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q     <= PTR_ZERO;
            r_ptr_q     <= PTR_ZERO;
            level_q     <= LVL_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[w_ptr_q] <= bus.w_data;
        end
    end

    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (level_q >= LVL_AF);
    assign bus.almost_empty = (level_q <= LVL_AE);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
        logic                  r_valid_q, r_valid_d;

        // Capture the head word on each accepted pop; otherwise hold data, drop valid.
        always_comb begin
            r_data_d  = r_data_q;
            r_valid_d = 1'b0;
            if (rd_acc_s) begin
                r_data_d  = mem_q[r_ptr_q];
                r_valid_d = 1'b1;
            end else begin
                r_data_d  = r_data_q;
                r_valid_d = 1'b0;
            end
        end

        // Registered read port.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data_q  <= {DATA_WIDTH{1'b0}};
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign bus.r_data  = r_data_q;
        assign bus.r_valid = r_valid_q;
    end else begin : g_comb
        assign bus.r_data  = mem_q[r_ptr_q];
        assign bus.r_valid = ~empty_s;
    end
endmodule

// File: tb/tb_fifo_level_unit.sv
// Self-checking bench: one instance with a combinational read port and one
// with the registered read port, both compared against a level model and a
// data scoreboard.
module tb_fifo_level_unit;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    fifo_level_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b0 ();
    fifo_level_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b1 ();

    fifo_level_unit #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(0))
        u_dut0 (.clk(clk), .reset(rst0), .bus(b0));
    fifo_level_unit #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(1))
        u_dut1 (.clk(clk), .reset(rst1), .bus(b1));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    int   m_lvl0 = 0;
    logic m_ovf0 = 1'b0;
    logic m_unf0 = 1'b0;
    int   m_lvl1 = 0;
    logic [7:0] m_rd1 = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status0();
        check_val("level0",  32'(b0.level),        32'(m_lvl0));
        check_val("full0",   32'(b0.full),         32'(m_lvl0 == 8));
        check_val("empty0",  32'(b0.empty),        32'(m_lvl0 == 0));
        check_val("afull0",  32'(b0.almost_full),  32'(m_lvl0 >= 6));
        check_val("aempty0", 32'(b0.almost_empty), 32'(m_lvl0 <= 1));
        check_val("ovf0",    32'(b0.overflow),     32'(m_ovf0));
        check_val("unf0",    32'(b0.underflow),    32'(m_unf0));
        check_val("rvalid0", 32'(b0.r_valid),      32'(m_lvl0 != 0));
    endtask

    task automatic step0(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
        logic [7:0] e;
        logic wacc, racc;
        @(negedge clk);
        b0.wr = w; b0.rd = r; b0.flush = f; b0.clr_err = c; b0.w_data = d;
        #1;
        wacc = w && (m_lvl0 != 8) && !f;
        racc = r && (m_lvl0 != 0) && !f;
        if (racc) begin
            e = sb0.pop_front();
            check_val("rdata0", 32'(b0.r_data), 32'(e));
        end
        if (wacc) sb0.push_back(d);
        m_ovf0 = (w && (m_lvl0 == 8) && !f) ? 1'b1 : (c ? 1'b0 : m_ovf0);
        m_unf0 = (r && (m_lvl0 == 0) && !f) ? 1'b1 : (c ? 1'b0 : m_unf0);
        if (f) begin
            m_lvl0 = 0;
            sb0.delete();
        end else begin
            m_lvl0 = m_lvl0 + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end
        @(posedge clk);
        #1;
        check_status0();
    endtask

    task automatic step1(input logic w, input logic r, input logic f, input logic [7:0] d);
        logic wacc, racc;
        @(negedge clk);
        b1.wr = w; b1.rd = r; b1.flush = f; b1.clr_err = 1'b0; b1.w_data = d;
        wacc = w && (m_lvl1 != 8) && !f;
        racc = r && (m_lvl1 != 0) && !f;
        if (racc) m_rd1 = sb1.pop_front();
        if (wacc) sb1.push_back(d);
        if (f) begin
            m_lvl1 = 0;
            sb1.delete();
        end else begin
            m_lvl1 = m_lvl1 + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end
        @(posedge clk);
        #1;
        check_val("rvalid1", 32'(b1.r_valid), 32'(racc));
        check_val("rdata1",  32'(b1.r_data),  32'(m_rd1));
        check_val("level1",  32'(b1.level),   32'(m_lvl1));
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        b0.wr = 1'b0; b0.rd = 1'b0; b0.flush = 1'b0; b0.clr_err = 1'b0; b0.w_data = 8'h00;
        b1.wr = 1'b0; b1.rd = 1'b0; b1.flush = 1'b0; b1.clr_err = 1'b0; b1.w_data = 8'h00;
        #12;
        check_status0();
        check_val("rst_rvalid1", 32'(b1.r_valid), 32'd0);
        check_val("rst_rdata1",  32'(b1.r_data),  32'd0);
        check_val("rst_level1",  32'(b1.level),   32'd0);
        check_val("rst_empty1",  32'(b1.empty),   32'd1);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        // Fill to full, then an overflowing write that must never be read.
        for (int i = 0; i < 8; i++) step0(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h11 + i));
        step0(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        step0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Drain in order.
        for (int i = 0; i < 8; i++) step0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        // Underflow, then set-beats-clear, then plain clear.
        step0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step0(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        step0(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Level 4, sustained simultaneous read/write across pointer wraps.
        for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) step0(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        // Level 5, flush with wr and rd pending, then fresh data first out.
        step0(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        step0(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        step0(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        step0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Registered read port: back-to-back pops, one-cycle valid pulses.
        step1(1'b1, 1'b0, 1'b0, 8'h01);
        step1(1'b1, 1'b0, 1'b0, 8'h02);
        step1(1'b0, 1'b1, 1'b0, 8'h00);
        step1(1'b0, 1'b1, 1'b0, 8'h00);
        step1(1'b0, 1'b0, 1'b0, 8'h00);
        step1(1'b1, 1'b0, 1'b0, 8'h33);
        step1(1'b1, 1'b0, 1'b0, 8'h44);
        step1(1'b0, 1'b1, 1'b0, 8'h00);
        // Asynchronous reset between clock edges.
        b1.rd = 1'b0;
        #1;
        rst1 = 1'b1;
        #1;
        check_val("arst_rvalid1", 32'(b1.r_valid), 32'd0);
        check_val("arst_rdata1",  32'(b1.r_data),  32'd0);
        check_val("arst_level1",  32'(b1.level),   32'd0);
        check_val("arst_empty1",  32'(b1.empty),   32'd1);
        sb1.delete();
        m_lvl1 = 0;
        m_rd1  = 8'h00;
        @(negedge clk);
        rst1 = 1'b0;
        // Flush with a pending read: no valid pulse, data held.
        step1(1'b1, 1'b0, 1'b0, 8'h77);
        step1(1'b0, 1'b1, 1'b1, 8'h00);
        step1(1'b0, 1'b1, 1'b0, 8'h00);
        check_val("unf1", 32'(b1.underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_level_unit.md
# fifo_level_unit

Parametrised synchronous FIFO that succeeds the basic UART buffer FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and an optional registered-output read mode. It sits between the UART rx/tx datapaths and the bus interface, so software can poll the fill level and use thresholds for interrupt generation.

## Interface
- ADDR_WIDTH, 3: depth D = 2^ADDR_WIDTH words, D ≥ 2.
- DATA_WIDTH, 8: word width.
- AF_LEVEL, 6: almost_full asserts when level ≥ AF_LEVEL; legal range 1..D.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL; legal range 0..D-1.
- OUT_REG, 0: 0 = head word shown combinationally; 1 = registered read data with r_valid.

Ports:
- clk  in  1  clock. One clock domain; all logic on rising edge.
- reset  in  1  reset, asynchronous and active-high.
- wr  in  1  write request.
- rd  in  1  read (pop) request.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  clears the overflow/underflow sticky flags.
- w_data  in  DATA_WIDTH  write data.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  OUT_REG=1: r_data updated this cycle. OUT_REG=0: equals ~empty.
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  threshold flags.
- level  out  ADDR_WIDTH+1  number of stored words, 0..D.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Internal state: write pointer, read pointer (ADDR_WIDTH bits each, wrap modulo D), level register (ADDR_WIDTH+1 bits), and a D×DATA_WIDTH storage array. Storage is not reset.
- wr_acc = wr & ~full & ~flush.
- rd_acc = rd & ~empty & ~flush.
- On wr_acc: mem[w_ptr] <= w_data; w_ptr increments.
- On rd_acc: r_ptr increments.
- level update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither occur.
- Simultaneous wr and rd:
  - When full, only the read is accepted; the write is dropped and sets overflow.
  - When empty, only the write is accepted; the read sets underflow.
- Derived outputs:
  - full = (level == D), empty = (level == 0).
  - almost_full = (level ≥ AF_LEVEL), almost_empty = (level ≤ AE_LEVEL).
  - All are combinational from the level register.
- overflow sets on wr & full & ~flush. underflow sets on rd & empty & ~flush.
- clr_err clears both flags. If a set condition and clr_err occur in the same cycle, set wins.
- flush:
  - Pointers and level go to 0. Pending wr/rd in that cycle are ignored, with no error flags set.
  - OUT_REG=1: r_valid <= 0 and r_data holds its value.
- Read data, OUT_REG=0: r_data = mem[r_ptr] combinationally. It is valid whenever empty=0, and rd pops it.
- Read data, OUT_REG=1: on rd_acc, r_data <= mem[r_ptr] and r_valid <= 1. Otherwise r_valid <= 0 and r_data holds its value.

## Timing
- Reset values:
  - w_ptr, r_ptr, level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - r_valid = 0 (OUT_REG=1).
  - r_data = 0 (OUT_REG=1). With OUT_REG=0, r_data is undefined while empty.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Contents are lost.
- Latencies:
  - Flags and level reflect an accepted operation from the clock edge that accepts it, i.e. visible in the next cycle.
  - Write-to-read latency: a word written at edge N is readable (OUT_REG=0: on r_data) after edge N. Earliest pop is at edge N+1.
  - OUT_REG=1: data popped at edge N appears on r_data with r_valid=1 after edge N, for exactly one cycle per pop.
- Throughput: one write and one read per cycle, sustained.
- Wrap-around is silent; there is no pointer extra bit because level disambiguates full from empty.

## Test plan
- Reset, then write 0x11..0x18 on 8 consecutive cycles (D=8) -> full=1, level=8, almost_full rose after the 6th write. Read 8 times -> data 0x11..0x18 in order, empty=1, almost_empty=1 from level 1.
- Full FIFO, wr=1 with w_data=0xAA for 1 cycle -> overflow=1, level stays 8, 0xAA is never read. Then clr_err -> overflow=0.
- Empty FIFO, rd=1 -> underflow=1, level 0, pointers unchanged. Assert rd and clr_err together -> underflow stays 1.
- Level 4, wr and rd together for 20 cycles with an incrementing pattern -> level stays 4, pointers wrap at least twice, output sequence is intact.
- Level 5, flush=1 with wr=rd=1 -> next cycle level=0, empty=1, no error flags set. Write 0x5A -> 0x5A is read first.
- OUT_REG=1: write 0x01, 0x02, then rd at edges N and N+1 -> r_valid=1 with r_data 0x01, then 0x02, then r_valid=0. Assert reset during the sequence -> r_valid=0, r_data=0, level=0 without a clock edge.
